// File: rtl/hub75_scan_ctrl_if.sv
// Fetch/shift handshake between the scan controller and the line shifter.
// The controller (master) requests a plane; the shifter (slave) reports busy.
interface hub75_scan_ctrl_if #(
  parameter int unsigned ROWS = 32,
  parameter int unsigned BITS = 8
);
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned BW = (BITS > 1) ? $clog2(BITS) : 1;

  logic          fetchshift_start;
  logic          fetchshift_busy;
  logic [BW-1:0] bit_out;
  logic [RW-1:0] row_out;

  modport master (
    output fetchshift_start,
    output bit_out,
    output row_out,
    input  fetchshift_busy
  );

  modport slave (
    input  fetchshift_start,
    input  bit_out,
    input  row_out,
    output fetchshift_busy
  );
endinterface

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller: binary-coded-modulation plane sequencing, blanking, latch and row select.
// Optional macro HUB75_SCAN_ADDR_EN adds a row_addr output for direct-address panels.
module hub75_scan_ctrl #(
  parameter int unsigned ROWS      = 32,
  parameter int unsigned BITS      = 8,
  parameter int unsigned BASE_ON   = 64,
  parameter int unsigned BLANK_GAP = 4
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [7:0]               brightness,
  hub75_scan_ctrl_if.master        fetch,
  output logic                     lat,
  output logic                     blank,
  output logic                     row_clk,
  output logic                     row_data,
  output logic                     frame_start
`ifdef HUB75_SCAN_ADDR_EN
  ,
  output logic [$clog2(ROWS)-1:0]  row_addr
`endif
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned BW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int unsigned TW = $clog2(BASE_ON) + BITS + 9;
  localparam int unsigned CW = TW - 8;
  localparam int unsigned GW = $clog2(BLANK_GAP) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StShiftWait,
    StOnWait,
    StBlank,
    StLatch,
    StOn
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    bright_q, bright_d;
  logic [TW-1:0] prod;
  logic          row_chg;
`ifdef HUB75_SCAN_ADDR_EN
  logic [RW-1:0] row_addr_q, row_addr_d;
`endif

  // Full-width on-time product; the >>8 scales by (brightness+1)/256.
  assign prod    = (TW'(BASE_ON) << bit_q) * (TW'(bright_q) + TW'(1));
  assign row_chg = (bit_q == '0);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      bit_q    <= '0;
      row_q    <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      bright_q <= '0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      bright_q <= bright_d;
    end
  end

`ifdef HUB75_SCAN_ADDR_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      row_addr_q <= '0;
    end else begin
      row_addr_q <= row_addr_d;
    end
  end

  assign row_addr = row_addr_q;
`endif

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    row_d       = row_q;
    gap_d       = gap_q;
    bright_d    = bright_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    lat         = 1'b0;
    row_clk     = 1'b0;
    row_data    = 1'b0;
    frame_start = 1'b0;
    fetch.fetchshift_start = 1'b0;
`ifdef HUB75_SCAN_ADDR_EN
    row_addr_d  = row_addr_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StStart;
      end
      StStart: begin
        fetch.fetchshift_start = 1'b1;
        frame_start = (row_q == '0) && (bit_q == '0);
        gap_d       = '0;
        state_d     = StShiftWait;
      end
      StShiftWait: begin
        // gap_q doubles as the "first cycle seen" flag so stale busy is ignored.
        gap_d = GW'(1);
        if (gap_q != '0 && !fetch.fetchshift_busy) state_d = StOnWait;
      end
      StOnWait: begin
        if (cnt_q == '0) begin
          gap_d = '0;
          if (enable) begin
            state_d = StBlank;
          end else begin
            state_d = StIdle;
            bit_d   = '0;
            row_d   = '0;
          end
        end
      end
      StBlank: begin
        if (row_chg && gap_q == GW'(0)) begin
          row_data = (row_q == '0);
        end else if (row_chg && gap_q == GW'(1)) begin
          row_clk  = 1'b1;
          row_data = (row_q == '0);
`ifdef HUB75_SCAN_ADDR_EN
          row_addr_d = row_q;
`endif
        end
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(BLANK_GAP - 1)) state_d = StLatch;
      end
      StLatch: begin
        lat      = 1'b1;
        bright_d = brightness;
        state_d  = StOn;
      end
      StOn: begin
        cnt_d = CW'(prod >> 8);
        if (bit_q == BW'(BITS - 1)) begin
          bit_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          bit_d = bit_q + BW'(1);
        end
        state_d = StStart;
      end
      default: state_d = StIdle;
    endcase
  end

  assign blank         = (cnt_q == '0);
  assign fetch.bit_out = bit_q;
  assign fetch.row_out = row_q;

endmodule

// File: doc/hub75_scan_ctrl.md
HUB75_SCAN_CTRL -- requirements
Module: hub75_scan_ctrl

Interface
REQ-001 The block SHALL have parameter ROWS, default 32, meaning scan rows per panel (power of two, 2..64).
REQ-002 The block SHALL have parameter BITS, default 8, meaning bit planes per row (1..10).
REQ-003 The block SHALL have parameter BASE_ON, default 64, meaning LSB-plane on-time in sys_clk cycles at full brightness.
REQ-004 The block SHALL have parameter BLANK_GAP, default 4, meaning blank cycles before each latch (minimum 2).
REQ-005 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- sys_clk  in  1  system clock; the block has one clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run scanning.
- brightness  in  8  global brightness, 0..255.
- fetchshift_busy  in  1  line shifter busy.
- fetchshift_start  out  1  one-cycle pulse to start shifting the plane given by bit_out/row_out.
- bit_out  out  clog2(BITS)  plane being shifted.
- row_out  out  clog2(ROWS)  row being shifted.
- lat  out  1  panel latch.
- blank  out  1  panel output disable, high = dark.
- row_clk  out  1  row-select shift register clock.
- row_data  out  1  row-select shift register data.
- frame_start  out  1  one-cycle pulse at start of each frame.

Function
REQ-006 The FSM SHALL have states IDLE, START, SHIFT_WAIT, ON_WAIT, BLANK, LATCH and ON.
REQ-007 In IDLE with enable=1, the FSM SHALL go to START on the next cycle.
REQ-008 In START, the block SHALL pulse fetchshift_start for 1 cycle and then go to SHIFT_WAIT.
REQ-009 The same START cycle SHALL pulse frame_start when row_out=0 and bit_out=0.
REQ-010 SHIFT_WAIT SHALL ignore fetchshift_busy in its first cycle and SHALL go to ON_WAIT on the first later cycle with fetchshift_busy=0.
REQ-011 ON_WAIT SHALL hold until the on-time counter is 0.
REQ-012 On leaving ON_WAIT, the FSM SHALL go to BLANK if enable=1, or to IDLE with blank=1 and row_out/bit_out cleared to 0 if enable=0.
REQ-013 BLANK SHALL drive blank=1 for exactly BLANK_GAP cycles and then go to LATCH.
REQ-014 In BLANK, when the pending plane has bit 0 (row change), cycle 0 SHALL drive row_data=1 if the pending row is 0 and 0 otherwise.
REQ-015 In BLANK, when the pending plane has bit 0, cycle 1 SHALL drive row_clk=1 with row_data held.
REQ-016 In BLANK, row_clk and row_data SHALL be 0 in all other cycles.
REQ-017 LATCH SHALL drive lat=1 and blank=1 for exactly 1 cycle and SHALL sample brightness.
REQ-018 ON SHALL last 1 cycle, in which the on-time counter is loaded with T = ((BASE_ON << b) * (brightness + 1)) >> 8, where b is the latched plane.
REQ-019 Within the same ON cycle, bit_out/row_out SHALL advance to the next plane and the FSM SHALL go to START.
REQ-020 The on-time counter SHALL be decremented once per cycle while nonzero.
REQ-021 blank SHALL be 0 exactly while the counter is nonzero.
REQ-022 When T=0, the plane SHALL stay dark.
REQ-023 T arithmetic SHALL be full width with no truncation before the shift (width clog2(BASE_ON) + BITS + 9).
REQ-024 Plane order SHALL be bit 0..BITS-1 within a row; after BITS-1, bit SHALL wrap to 0 and row SHALL increment.
REQ-025 After row ROWS-1, bit 0, row SHALL wrap to row 0.
REQ-026 Shifting of plane k+1 (START/SHIFT_WAIT) SHALL overlap the display of plane k.
REQ-027 The first ON_WAIT after IDLE SHALL see counter=0 and proceed immediately.
REQ-028 fetchshift_busy SHALL be ignored outside SHIFT_WAIT.
REQ-029 If enable falls in any state other than ON_WAIT, that state's sequence SHALL complete; the transition to IDLE occurs at the next ON_WAIT exit.

Reset
REQ-030 While rst_n=0, the state SHALL be IDLE and blank SHALL be 1.
REQ-031 While rst_n=0, lat, row_clk, row_data, fetchshift_start and frame_start SHALL be 0.
REQ-032 While rst_n=0, bit_out, row_out and the on-time counter SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL force these values asynchronously.
REQ-034 After rst_n rises, the block SHALL restart at row 0, bit 0, with frame_start.

Configuration
REQ-035 With HUB75_SCAN_ADDR_EN defined, the block SHALL add output row_addr [clog2(ROWS)] for direct-address panels, loaded with the pending row in BLANK cycle 1 on row change and reset to 0.
REQ-036 Without HUB75_SCAN_ADDR_EN, row_addr SHALL be absent and all other behaviour SHALL be identical.

Verification
(ROWS=4, BITS=3, BASE_ON=8, BLANK_GAP=2, busy held high 5 cycles after each start.)
REQ-037 The bench SHALL cover: reset release with enable=1 -> frame_start coincides with the first fetchshift_start, bit_out=0, row_out=0, blank=1 until the first ON.
REQ-038 The bench SHALL cover: brightness=255 -> blank-low widths repeat 8, 16, 32 cycles per row.
REQ-039 The bench SHALL cover: brightness=127 -> widths 4, 8, 16; brightness=0 -> widths 0, 0, 0, with blank never low.
REQ-040 The bench SHALL cover: one full frame -> row_clk pulses 4 times, row_data=1 only at the row-0 pulse, 12 lat pulses, frame_start once per 12 starts.
REQ-041 The bench SHALL cover: enable dropped during row 2, bit 1 display -> blank=1 after that plane, no further lat, restart at row 0, bit 0 with frame_start.
REQ-042 The bench SHALL cover: rst_n pulsed low mid-LATCH -> lat and blank take reset values in the same cycle; with HUB75_SCAN_ADDR_EN, row_addr reads 0, 1, 2, 3, 0.
